// File: rtl/uart_pkg.sv
// Shared definitions for the result UART transmitter: frame constants and
// the FSM state encoding used by result_uart_tx.
package uart_pkg;

  localparam int   DATA_W      = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t IDLE   = 3'd0;
  localparam uart_state_t START  = 3'd1;
  localparam uart_state_t DATA   = 3'd2;
  localparam uart_state_t PARITY = 3'd3;
  localparam uart_state_t STOP   = 3'd4;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal-count cycle so the FSM can advance exactly once per bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             at_last;

  assign at_last = (cnt_reg == CNT_LAST);
  assign tick    = en && at_last;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = at_last ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Serialises the adder result as a UART frame: start, 8 data bits LSB first,
// optional parity, then 1 or 2 stop bits. Valid/ready input handshake.
module result_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx,
  output logic              busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("result_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("result_uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic            PAR_EN    = (PARITY_EN != 0);
  localparam logic            PAR_ODD   = (PARITY_ODD != 0);
  localparam logic            STOP_LAST = (STOP_BITS == 2);
  localparam logic [2:0]      BIT_LAST  = 3'(DATA_W - 1);

  uart_state_t       state_reg,    state_next;
  logic [DATA_W-1:0] shift_reg,    shift_next;
  logic [2:0]        bit_idx_reg,  bit_idx_next;
  logic              stop_idx_reg, stop_idx_next;
  logic              parity_reg,   parity_next;
  logic              tx_reg,       tx_next;
  logic              busy_reg,     busy_next;

  logic accept;
  logic bit_tick;
  logic parity_in;

  assign data_ready = (state_reg == IDLE);
  assign accept     = data_valid && data_ready;
  assign tx         = tx_reg;
  assign busy       = busy_reg;

  // Parity is taken from the byte as accepted, since the shifter discards it.
  assign parity_in = (^data_in) ^ PAR_ODD;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (busy_reg),
    .tick  (bit_tick)
  );

  // tx_next always carries the level of the bit that starts at the next edge,
  // so the line is a plain flop output.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    stop_idx_next = stop_idx_reg;
    parity_next   = parity_reg;
    tx_next       = tx_reg;
    busy_next     = busy_reg;

    case (state_reg)
      IDLE: begin
        tx_next = IDLE_LEVEL;
        if (accept) begin
          state_next    = START;
          shift_next    = data_in;
          parity_next   = parity_in;
          bit_idx_next  = 3'd0;
          stop_idx_next = 1'b0;
          tx_next       = START_LEVEL;
          busy_next     = 1'b1;
        end
      end

      START: begin
        if (bit_tick) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
        end
      end

      DATA: begin
        if (bit_tick) begin
          shift_next = {1'b0, shift_reg[DATA_W-1:1]};
          if (bit_idx_reg == BIT_LAST) begin
            if (PAR_EN) begin
              state_next = PARITY;
              tx_next    = parity_reg;
            end else begin
              state_next = STOP;
              tx_next    = IDLE_LEVEL;
            end
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            tx_next      = shift_reg[1];
          end
        end
      end

      PARITY: begin
        if (bit_tick) begin
          state_next = STOP;
          tx_next    = IDLE_LEVEL;
        end
      end

      STOP: begin
        tx_next = IDLE_LEVEL;
        if (bit_tick) begin
          if (stop_idx_reg == STOP_LAST) begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end else begin
            stop_idx_next = stop_idx_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = IDLE_LEVEL;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= 3'd0;
      stop_idx_reg <= 1'b0;
      parity_reg   <= 1'b0;
      tx_reg       <= IDLE_LEVEL;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      stop_idx_reg <= stop_idx_next;
      parity_reg   <= parity_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
    end
  end

endmodule
